// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer
//   Victim/writeback FIFO between the L2 data arrays and physical memory.
//   Dirty lines evicted by L2 control are queued with their address and
//   drained to pmem in FIFO order, one line per write transaction. A fully
//   associative lookup port lets the L2 find a pending victim on a miss so it
//   never refills stale data from pmem.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   evict_valid/addr/data        push request from L2 control
//   evict_ready                  !full (from registered count)
//   lookup_addr                  probe address; offset bits ignored
//   lookup_hit/lookup_data       youngest matching valid entry; data 0 on miss
//   pmem_write/address/wdata     head-entry write request to pmem
//   pmem_resp                    one-cycle write-complete pulse
//   empty, full, count           occupancy status
module l2_writeback_buffer #(
  parameter int unsigned WIDTH    = 256,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 5,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       evict_valid,
  input  logic [ADDR_W-1:0]          evict_addr,
  input  logic [WIDTH-1:0]           evict_data,
  output logic                       evict_ready,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [WIDTH-1:0]           lookup_data,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [WIDTH-1:0]           pmem_wdata,
  input  logic                       pmem_resp,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  // Selects the line-address bits; the offset bits never take part in a match.
  localparam logic [ADDR_W-1:0] TAG_MASK =
    {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];

  logic push;
  logic pop;
  logic [PTR_W-1:0] idx;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_MAX);
  assign count        = count_q;
  assign evict_ready  = !full;
  assign pmem_write   = (state_q == ST_WRITE);
  assign pmem_address = addr_q[rd_ptr_q];
  assign pmem_wdata   = data_q[rd_ptr_q];

  assign push = evict_valid && !full;
  assign pop  = (state_q == ST_WRITE) && pmem_resp;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;

    case (state_q)
      ST_IDLE:  if (!empty) state_d = ST_WRITE;
      ST_WRITE: if (pmem_resp) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Pop and push never target the same slot: a pop needs a non-empty
    // buffer and a push a non-full one, so the pointers differ.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_ONE;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Walk from the head (oldest) toward the tail so the youngest match
  // overwrites older ones.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (valid_q[idx] && (((addr_q[idx] ^ lookup_addr) & TAG_MASK) == '0)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Line storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= evict_addr;
      data_q[wr_ptr_q] <= evict_data;
    end
  end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
module tb_l2_writeback_buffer;

  logic         clk;
  logic         rst_n;
  logic         evict_valid;
  logic [31:0]  evict_addr;
  logic [255:0] evict_data;
  logic         evict_ready;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [255:0] lookup_data;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic         empty;
  logic         full;
  logic [2:0]   count;

  int unsigned n_checks;
  int unsigned n_bad;

  logic [255:0] d_beef, d_a, d_b, d_c, d_1, d_2, d_3, d_4, d_5, d_x, d_y, d_z;

  l2_writeback_buffer #(
    .WIDTH(256),
    .ADDR_W(32),
    .OFFSET_W(5),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .evict_valid(evict_valid),
    .evict_addr(evict_addr),
    .evict_data(evict_data),
    .evict_ready(evict_ready),
    .lookup_addr(lookup_addr),
    .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .empty(empty),
    .full(full),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [255:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    tick();
    evict_valid = 1'b0;
  endtask

  // Wait (bounded) for a write request, check the head line, then complete it.
  task automatic drain_one(input string tag, input logic [31:0] a, input logic [255:0] d);
    for (int n = 0; n < 10 && !pmem_write; n++) tick();
    check({tag, "_wr"}, pmem_write, 1);
    check({tag, "_addr"}, pmem_address, a);
    check({tag, "_data"}, pmem_wdata, d);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    d_beef = {8{32'hDEADBEEF}};
    d_a = {8{32'hAAAA0001}};
    d_b = {8{32'hBBBB0002}};
    d_c = {8{32'hCCCC0003}};
    d_1 = {8{32'h11110000}};
    d_2 = {8{32'h22220000}};
    d_3 = {8{32'h33330000}};
    d_4 = {8{32'h44440000}};
    d_5 = {8{32'h55550000}};
    d_x = {8{32'h0F0F0F0F}};
    d_y = {8{32'h1E1E1E1E}};
    d_z = {8{32'h2D2D2D2D}};

    rst_n       = 1'b1;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    lookup_addr = '0;
    pmem_resp   = 1'b0;

    // 1: reset state
    #3 rst_n = 1'b0;
    tick();
    tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ready", evict_ready, 1);
    check("rst_pwrite", pmem_write, 0);
    check("rst_hit", lookup_hit, 0);
    rst_n = 1'b1;
    tick();

    // 2: single line latency and completion
    push(32'h00001A40, d_beef);                 // E0
    check("t2_count_e0", count, 1);
    check("t2_pwrite_e0", pmem_write, 0);
    tick();                                     // E1
    check("t2_pwrite_e1", pmem_write, 1);
    check("t2_addr_e1", pmem_address, 32'h00001A40);
    check("t2_data_e1", pmem_wdata, d_beef);
    tick();
    tick();                                     // E3, still waiting
    check("t2_pwrite_e3", pmem_write, 1);
    check("t2_addr_e3", pmem_address, 32'h00001A40);
    pmem_resp = 1'b1;
    tick();                                     // E4
    pmem_resp = 1'b0;
    check("t2_count_e4", count, 0);
    check("t2_pwrite_e4", pmem_write, 0);
    check("t2_empty_e4", empty, 1);

    // 3: fill, overflow drop, FIFO order
    push(32'h00001000, d_1);
    push(32'h00002000, d_2);
    push(32'h00003000, d_3);
    push(32'h00004000, d_4);
    check("t3_full", full, 1);
    check("t3_ready", evict_ready, 0);
    check("t3_count4", count, 4);
    push(32'h00000500, d_5);
    check("t3_count_drop", count, 4);
    lookup_addr = 32'h00000500;
    #1 check("t3_drop_hit", lookup_hit, 0);
    drain_one("t3_l1", 32'h00001000, d_1);
    check("t3_count3", count, 3);
    check("t3_ready3", evict_ready, 1);
    drain_one("t3_l2", 32'h00002000, d_2);
    drain_one("t3_l3", 32'h00003000, d_3);
    drain_one("t3_l4", 32'h00004000, d_4);
    check("t3_count0", count, 0);
    tick();
    tick();
    check("t3_idle_pwrite", pmem_write, 0);

    // 4: lookup priority, offset masking, miss, same-cycle push invisibility
    push(32'h00000100, d_a);
    push(32'h0000011F, d_b);
    lookup_addr = 32'h00000100;
    #1;
    check("t4_hit", lookup_hit, 1);
    check("t4_data_young", lookup_data, d_b);
    lookup_addr = 32'h00000200;
    #1;
    check("t4_miss_hit", lookup_hit, 0);
    check("t4_miss_data", lookup_data, 0);
    lookup_addr = 32'h00000300;
    evict_valid = 1'b1;
    evict_addr  = 32'h00000300;
    evict_data  = d_c;
    #1;
    check("t4_same_cycle", lookup_hit, 0);
    tick();
    evict_valid = 1'b0;
    check("t4_next_cycle", lookup_hit, 1);
    check("t4_next_data", lookup_data, d_c);
    drain_one("t4_l1", 32'h00000100, d_a);
    drain_one("t4_l2", 32'h0000011F, d_b);
    drain_one("t4_l3", 32'h00000300, d_c);
    check("t4_count0", count, 0);

    // 5: simultaneous push and pop
    push(32'h00000600, d_x);
    push(32'h00000700, d_y);
    check("t5_count2", count, 2);
    check("t5_pwrite", pmem_write, 1);
    check("t5_head", pmem_address, 32'h00000600);
    evict_valid = 1'b1;
    evict_addr  = 32'h00000800;
    evict_data  = d_z;
    pmem_resp   = 1'b1;
    tick();
    evict_valid = 1'b0;
    pmem_resp   = 1'b0;
    check("t5_count_hold", count, 2);
    drain_one("t5_l2", 32'h00000700, d_y);
    drain_one("t5_l3", 32'h00000800, d_z);
    check("t5_count0", count, 0);

    // 6: asynchronous reset mid-write
    push(32'h00000900, d_a);
    tick();
    check("t6_pwrite_pre", pmem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_pwrite_async", pmem_write, 0);
    check("t6_count_async", count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("t6_count_after_resp", count, 0);
    check("t6_empty_after_resp", empty, 1);
    tick();
    check("t6_pwrite_after", pmem_write, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
